// File: rtl/ad_sample_filter_pkg.sv
// Shared types and defaults for the ADC sample filter.
package ad_filter_pkg;
   typedef enum logic {FILL = 1'b0, RUN = 1'b1} state_t;

   localparam int DEF_SAMPLE_DIV = 100000;
   localparam int DEF_LOG2_LEN   = 3;
   localparam int AD_W           = 8;

   // Accumulator width: one ADC byte plus log2 of the window length.
   function automatic int sum_w(input int log2_len);
      return AD_W + log2_len;
   endfunction
endpackage

// File: rtl/ad_sample_filter_if.sv
// Signal bundle between the ADC filter and its neighbours.
interface ad_sample_filter_if;
   import ad_filter_pkg::*;

   logic [AD_W-1:0] ad_data;
   logic            en;
   logic [AD_W-1:0] th_high;
   logic [AD_W-1:0] th_low;
   logic [AD_W-1:0] avg_data;
   logic            avg_valid;
   logic            filled;
   logic            over;

   modport master (output ad_data, en, th_high, th_low,
                   input  avg_data, avg_valid, filled, over);
   modport slave  (input  ad_data, en, th_high, th_low,
                   output avg_data, avg_valid, filled, over);
endinterface

// File: rtl/ad_sample_filter_tick_gen.sv
// Free-running sample-rate divider; emits a registered one-cycle tick.
module sample_tick_gen
   import ad_filter_pkg::*;
#(
   parameter int SAMPLE_DIV = DEF_SAMPLE_DIV
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick
);
   localparam int CNT_W = $clog2(SAMPLE_DIV);

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (!en) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else if (cnt == CNT_W'(SAMPLE_DIV - 1)) begin
         cnt  <= '0;
         tick <= 1'b1;
      end else begin
         cnt  <= cnt + 1'b1;
         tick <= 1'b0;
      end
   end
endmodule

// File: rtl/ad_sample_filter.sv
// Moving-average filter over a circular buffer of ADC samples, with a
// hysteresis threshold flag on each published average.
module ad_sample_filter
   import ad_filter_pkg::*;
#(
   parameter int SAMPLE_DIV = DEF_SAMPLE_DIV,
   parameter int LOG2_LEN   = DEF_LOG2_LEN
) (
   input logic               clk,
   input logic               rst,
   ad_sample_filter_if.slave io
);
   localparam int LEN    = 1 << LOG2_LEN;
   localparam int SUM_W  = sum_w(LOG2_LEN);
   localparam int FILL_W = LOG2_LEN + 1;

   logic                tick;
   state_t              state, state_nxt;
   logic [AD_W-1:0]     win_buf [LEN];
   logic [LOG2_LEN-1:0] wr_ptr;
   logic [FILL_W-1:0]   fill_cnt;
   logic                fill_done;
   logic [SUM_W-1:0]    sum_p0, sum_nxt;
   logic                vld_p0, strobe_nxt, filled_p0;
   logic [AD_W-1:0]     avg_p1;
   logic                vld_p1, over_p1;

   function automatic logic [AD_W-1:0] avg_of(input logic [SUM_W-1:0] s);
      return AD_W'(s >> LOG2_LEN);
   endfunction

   function automatic logic hyst(input logic [AD_W-1:0] a, input logic [AD_W-1:0] hi,
                                 input logic [AD_W-1:0] lo, input logic cur);
      if (a > hi)      return 1'b1;
      else if (a < lo) return 1'b0;
      else             return cur;
   endfunction

   sample_tick_gen #(.SAMPLE_DIV(SAMPLE_DIV)) u_tick (
      .clk  (clk),
      .rst  (rst),
      .en   (io.en),
      .tick (tick)
   );

   always_comb begin
      state_nxt  = state;
      sum_nxt    = sum_p0;
      strobe_nxt = 1'b0;
      fill_done  = (fill_cnt == FILL_W'(LEN - 1));
      if (tick) begin
         case (state)
            FILL: begin
               sum_nxt = sum_p0 + SUM_W'(io.ad_data);
               if (fill_done) begin
                  state_nxt  = RUN;
                  strobe_nxt = 1'b1;
               end
            end
            RUN: begin
               sum_nxt    = sum_p0 + SUM_W'(io.ad_data) - SUM_W'(win_buf[wr_ptr]);
               strobe_nxt = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= FILL;
      else     state <= state_nxt;
   end

   // Stage p0: accumulate on the tick edge and advance the write pointer.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum_p0    <= '0;
         wr_ptr    <= '0;
         fill_cnt  <= '0;
         vld_p0    <= 1'b0;
         filled_p0 <= 1'b0;
      end else begin
         vld_p0 <= strobe_nxt;
         if (tick) begin
            sum_p0 <= sum_nxt;
            wr_ptr <= wr_ptr + 1'b1;
            if (state == FILL) fill_cnt <= fill_cnt + 1'b1;
            if (state == FILL && fill_done) filled_p0 <= 1'b1;
         end
      end
   end

   // Buffer contents are never reset: FILL treats old entries as zero.
   always_ff @(posedge clk) begin
      if (tick) win_buf[wr_ptr] <= io.ad_data;
   end

   // Stage p1: publish the average and update the hysteresis flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         avg_p1  <= '0;
         vld_p1  <= 1'b0;
         over_p1 <= 1'b0;
      end else begin
         vld_p1 <= vld_p0;
         if (vld_p0) begin
            avg_p1  <= avg_of(sum_p0);
            over_p1 <= hyst(avg_of(sum_p0), io.th_high, io.th_low, over_p1);
         end
      end
   end

   assign io.avg_data  = avg_p1;
   assign io.avg_valid = vld_p1;
   assign io.filled    = filled_p0;
   assign io.over      = over_p1;
endmodule

// File: tb/tb_ad_sample_filter.sv
// Scoreboard bench for ad_sample_filter against a window-average reference model.
module tb_ad_sample_filter;
   import ad_filter_pkg::*;

   localparam int DIV = 4;
   localparam int L2  = 3;
   localparam int LEN = 8;

   localparam logic [7:0] STEP_AVG [17] = '{8'h00, 8'h1F, 8'h3F, 8'h5F, 8'h7F, 8'h9F,
      8'hBF, 8'hDF, 8'hFF, 8'hDF, 8'hBF, 8'h9F, 8'h7F, 8'h5F, 8'h3F, 8'h1F, 8'h00};
   localparam logic STEP_OV [17] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
      1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ad_sample_filter_if io ();

   ad_sample_filter #(.SAMPLE_DIV(DIV), .LOG2_LEN(L2)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   typedef struct {
      logic [7:0] avg;
      logic       ov;
      int         due;
   } exp_t;

   exp_t       exp_q[$];
   int         win[$];
   int         m_cnt   = 0;
   bit         m_tick  = 1'b0;
   logic       m_over  = 1'b0;
   int         m_ticks = 0;
   int         cyc     = 0;
   logic [7:0] obs_avg[$];
   logic       obs_ov[$];
   int         tests   = 0;
   int         fails   = 0;

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic logic [7:0] obs_at(input int i);
      if (i < obs_avg.size()) return obs_avg[i];
      return 8'hxx;
   endfunction

   function automatic logic ov_at(input int i);
      if (i < obs_ov.size()) return obs_ov[i];
      return 1'bx;
   endfunction

   // Reference model: window of the last LEN samples, averaged on each sample.
   always @(posedge clk) begin
      if (rst) begin
         win.delete();
         exp_q.delete();
         m_cnt  = 0;
         m_tick = 1'b0;
         m_over = 1'b0;
      end else begin
         if (m_tick) begin
            int   s;
            exp_t e;
            m_ticks++;
            win.push_back(int'(io.ad_data));
            if (win.size() > LEN) void'(win.pop_front());
            if (win.size() == LEN) begin
               s = 0;
               foreach (win[i]) s += win[i];
               e.avg = 8'(s / LEN);
               if (e.avg > io.th_high)     m_over = 1'b1;
               else if (e.avg < io.th_low) m_over = 1'b0;
               e.ov  = m_over;
               e.due = cyc + 2;
               exp_q.push_back(e);
            end
         end
         if (io.en) begin
            if (m_cnt == DIV - 1) begin
               m_tick = 1'b1;
               m_cnt  = 0;
            end else begin
               m_tick = 1'b0;
               m_cnt++;
            end
         end else begin
            m_cnt  = 0;
            m_tick = 1'b0;
         end
      end
      cyc++;
   end

   always @(negedge clk) begin
      exp_t e;
      if (exp_q.size() > 0 && exp_q[0].due < cyc) begin
         tests++;
         fails++;
         $display("FAIL missing_strobe: got no strobe, expected at cycle %0d (now %0d)", exp_q[0].due, cyc);
         void'(exp_q.pop_front());
      end
      if (io.avg_valid === 1'b1) begin
         obs_avg.push_back(io.avg_data);
         obs_ov.push_back(io.over);
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_strobe: avg_valid=1 avg_data=%0h, expected no strobe (cycle %0d)", io.avg_data, cyc);
         end else begin
            e = exp_q.pop_front();
            chk("avg_data", io.avg_data, e.avg);
            chk("over", io.over, e.ov);
            chk("strobe_cycle", cyc, e.due);
         end
      end
      chk("filled", io.filled, win.size() == LEN);
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(negedge clk);
         #1;
      end
   endtask

   task automatic run_ticks(input int n, input logic [7:0] v);
      int tgt;
      io.ad_data = v;
      tgt = m_ticks + n;
      for (int k = 0; k < 200 * n && m_ticks < tgt; k++) step();
      if (m_ticks < tgt) begin
         tests++;
         fails++;
         $display("FAIL tick_timeout: got %0d ticks, expected %0d", m_ticks, tgt);
      end
   endtask

   task automatic quiesce_and_reset(input logic [7:0] hi, input logic [7:0] lo);
      io.en = 1'b0;
      step(3);
      io.th_high = hi;
      io.th_low  = lo;
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      io.en = 1'b1;
   endtask

   initial begin
      int k;
      int len;
      io.ad_data = 8'h00;
      io.en      = 1'b0;
      io.th_high = 8'h10;
      io.th_low  = 8'h08;
      step(2);
      rst = 1'b0;
      step();
      chk("reset_avg_data", io.avg_data, 0);
      chk("reset_avg_valid", io.avg_valid, 0);
      chk("reset_filled", io.filled, 0);
      chk("reset_over", io.over, 0);

      // Fill at constant input
      io.en = 1'b1;
      obs_avg.delete(); obs_ov.delete();
      run_ticks(7, 8'h80);
      step(3);
      chk("fill_no_strobe", obs_avg.size(), 0);
      chk("fill_not_filled", io.filled, 0);
      run_ticks(1, 8'h80);
      step(3);
      chk("fill_strobe_count", obs_avg.size(), 1);
      chk("fill_avg", obs_at(0), 8'h80);
      chk("fill_over", ov_at(0), 1);
      chk("fill_filled", io.filled, 1);

      // Enable gap
      io.en = 1'b0;
      step(3);
      obs_avg.delete(); obs_ov.delete();
      for (int i = 0; i < 17; i++) begin
         io.ad_data = 8'($urandom);
         step();
      end
      chk("gap_no_strobe", obs_avg.size(), 0);
      io.ad_data = 8'h40;
      io.en = 1'b1;
      k = 0;
      while (obs_avg.size() == 0 && k < 20) begin
         step();
         k++;
      end
      chk("reenable_latency", k, 6);
      chk("reenable_avg", obs_at(0), 8'h78);

      // Reset one cycle after a tick
      k = 0;
      while (!m_tick && k < 20) begin
         step();
         k++;
      end
      chk("tick_seen", m_tick, 1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_avg_data", io.avg_data, 0);
      chk("midrst_avg_valid", io.avg_valid, 0);
      chk("midrst_filled", io.filled, 0);
      chk("midrst_over", io.over, 0);
      obs_avg.delete(); obs_ov.delete();
      run_ticks(7, 8'h33);
      step(3);
      chk("refill_no_strobe", obs_avg.size(), 0);
      run_ticks(1, 8'h33);
      step(3);
      chk("refill_strobe_count", obs_avg.size(), 1);
      chk("refill_avg", obs_at(0), 8'h33);

      // Step up then down with hysteresis
      quiesce_and_reset(8'h90, 8'h70);
      obs_avg.delete(); obs_ov.delete();
      run_ticks(8, 8'h00);
      run_ticks(8, 8'hFF);
      run_ticks(8, 8'h00);
      step(3);
      chk("step_count", obs_avg.size(), 17);
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("step_avg[%0d]", i), obs_at(i), STEP_AVG[i]);
         chk($sformatf("step_over[%0d]", i), ov_at(i), STEP_OV[i]);
      end

      // Full-scale arithmetic
      quiesce_and_reset(8'hFF, 8'h00);
      obs_avg.delete(); obs_ov.delete();
      run_ticks(8, 8'hFF);
      chk("full_sum", 32'(dut.sum_p0), 2040);
      run_ticks(1, 8'h00);
      step(3);
      chk("full_avg", obs_at(0), 8'hFF);
      chk("full_then_zero_avg", obs_at(1), 8'hDF);

      // Randomized traffic: random data, enable gaps, thresholds and resets
      for (int seg = 0; seg < 25; seg++) begin
         io.en = 1'b1;
         len = $urandom_range(20, 80);
         for (int i = 0; i < len; i++) begin
            io.ad_data = 8'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            step();
         end
         rst = 1'b0;
         io.en = 1'b0;
         step(3);
         io.th_high = 8'($urandom);
         io.th_low  = 8'($urandom);
         step($urandom_range(1, 10));
      end

      io.en = 1'b0;
      step(5);
      chk("scoreboard_drained", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
